pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the architectural program counter.
- Each enabled cycle it presents pc and pc_4 to fetch and to the next-PC logic, then commits the returned pc_new.
- Implements the run/halt/stall sequencing around the commit.
- Keeps saturating performance counters (cycles, taken branches, jumps) for the debug display.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- en  input  1  core step enable (free-run or single-step pulse); no state changes when 0.
- stall  input  1  hazard hold; PC and jump/branch counters frozen this cycle.
- halt  input  1  halt request (syscall halt), qualified by en.
- resume  input  1  leave HALT, qualified by en.
- pc_new  input  32  next-PC value from the next-PC logic.
- branched  input  1  current conditional branch taken.
- is_jump  input  1  current instruction is an unconditional jump (26-bit or register form).
- pc  output  32  current PC.
- pc_4  output  32  pc + 4, combinational, wraps modulo 2^32.
- halted  output  1  1 while state is HALT or FAULT.
- fault  output  1  1 while state is FAULT.
- cnt_cycle  output  CNT_W  enabled cycles spent in RUN.
- cnt_branch  output  CNT_W  committed taken branches.
- cnt_jump  output  CNT_W  committed jumps.

Behaviour:
- Reset (rst_n == 0 at clock edge):
  - pc = RESET_PC; state = RUN; all counters = 0; halted = 0; fault = 0.
  - Reset overrides every other input, including mid-halt and mid-fault.
- States: RUN, HALT, FAULT. halted and fault are registered decodes of the state.
- en == 0: hold everything; halt, resume and stall are ignored.
- RUN with en == 1, evaluated in this priority:
  1. halt == 1: state -> HALT. pc is unchanged and still points at the halting instruction. No counter increments except cnt_cycle.
  2. stall == 1: pc held; cnt_branch and cnt_jump are not incremented.
  3. Otherwise, commit: pc <= pc_new. cnt_branch += branched; cnt_jump += is_jump.
  - cnt_cycle += 1 in every RUN cycle with en == 1, regardless of halt or stall.
- HALT with en == 1:
  - resume == 1: pc <= pc + 4 (skips the halting instruction); state -> RUN. No counter increments.
  - Otherwise hold. halt, stall, pc_new and branched are ignored.
- FAULT: terminal. Only reset exits it; pc keeps the last good value.
- Latency: a pc_new presented in cycle N is visible on pc in cycle N+1. pc_4 follows pc combinationally in the same cycle.
- Counters saturate at all-ones and never wrap.
- branched and is_jump both high in the same commit cycle: both counters increment. This case is illegal upstream but must not be masked.
- halt and resume both high in RUN: halt wins. Both high in HALT: resume wins.
- pc_new is never range-checked. pc = 32'hFFFF_FFFC gives pc_4 = 32'h0000_0000.

Optional Feature:
- PC_ALIGN_CHECK_EN defined:
  - A commit with pc_new[1:0] != 2'b00 does not load pc and moves the state to FAULT.
  - fault = 1 and halted = 1 from the next cycle.
  - cnt_branch and cnt_jump are not incremented for that cycle.
- PC_ALIGN_CHECK_EN undefined:
  - pc <= {pc_new[31:2], 2'b00}.
  - FAULT is unreachable; fault is tied to 0.

Test Plan:
1. Reset with RESET_PC = 32'h0000_3000, then en = 1 and pc_new = pc_4 for 3 cycles -> pc goes 3000, 3004, 3008, 300C; cnt_cycle = 3; cnt_branch = cnt_jump = 0.
2. At pc = 32'h0000_0010: drive branched = 1, pc_new = 32'h0000_0040 -> next pc = 40 and cnt_branch = 1. Then drive is_jump = 1, pc_new = 32'h0000_0100 -> pc = 100, cnt_jump = 1.
3. stall = 1 for 2 enabled cycles with branched = 1 -> pc unchanged, cnt_branch unchanged, cnt_cycle += 2. Also: en = 0 with halt = 1 -> no state change.
4. At pc = 32'h0000_0020: assert halt -> halted = 1 next cycle and pc stays 20. Hold 5 cycles, then resume -> pc = 24, halted = 0. With halt and resume together in RUN -> enters HALT.
5. Preload cnt_branch near saturation via a long run with CNT_W = 4: 17 taken branches -> cnt_branch = 4'hF. Then assert rst_n = 0 in HALT -> pc = RESET_PC, all counters = 0, state RUN.
6. PC_ALIGN_CHECK_EN defined: pc_new = 32'h0000_0042 -> fault = 1, pc unchanged, and it stays faulted despite resume. Undefined: same stimulus -> pc = 32'h0000_0040, fault = 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Owns the architectural program counter and the run/halt/fault sequencing
// around each PC commit. It also keeps saturating performance counters for
// the debug display.
//
// Each enabled cycle the current pc and pc_4 go to fetch and to the next-PC
// logic. The returned pc_new is committed on the next rising edge, unless a
// halt, a stall or a fault blocks the commit.
//
// Optional build macro:
//   PC_ALIGN_CHECK_EN - when defined, a commit of a misaligned pc_new
//                       (pc_new[1:0] != 0) is refused and the sequencer
//                       enters the terminal FAULT state. When undefined,
//                       pc_new is force-aligned and fault is tied to 0.
//
// Parameters:
//   RESET_PC   PC value loaded on reset
//   CNT_W      width of each performance counter
//
// Ports:
//   clk         core clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   en          step enable; nothing changes while low
//   stall       hazard hold; pc and the branch/jump counters freeze
//   halt        halt request (qualified by en)
//   resume      leave HALT (qualified by en)
//   pc_new      next-PC value from the next-PC logic
//   branched    current conditional branch taken
//   is_jump     current instruction is an unconditional jump
//   pc          current PC
//   pc_4        pc + 4, combinational, wraps modulo 2^32
//   halted      1 while in HALT or FAULT
//   fault       1 while in FAULT
//   cnt_cycle   enabled cycles spent in RUN
//   cnt_branch  committed taken branches
//   cnt_jump    committed jumps
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             stall,
  input  logic             halt,
  input  logic             resume,
  input  logic [31:0]      pc_new,
  input  logic             branched,
  input  logic             is_jump,
  output logic [31:0]      pc,
  output logic [31:0]      pc_4,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cnt_cycle,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_jump
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t state;
  logic   fault_q;

  // Counters stick at all-ones instead of wrapping, so that a saturated
  // value on the debug display reads as "at least this many".
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic inc);
    if (inc && (v != {CNT_W{1'b1}}))
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    else
      return v;
  endfunction

  // The fall-through address is also the resume target after a halt, so it
  // is shared by the output and the HALT -> RUN transition.
  assign pc_4 = pc + 32'd4;

  // One sequential block holds the whole sequencer. halted and fault are
  // registered decodes of the next state, so they change together with the
  // state itself. In RUN, halt outranks stall, and stall outranks the commit.
  // cnt_cycle counts every enabled RUN cycle, whichever of these wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      state      <= RUN;
      halted     <= 1'b0;
      fault_q    <= 1'b0;
      cnt_cycle  <= '0;
      cnt_branch <= '0;
      cnt_jump   <= '0;
    end else if (en) begin
      case (state)
        RUN: begin
          cnt_cycle <= sat_inc(cnt_cycle, 1'b1);
          if (halt) begin
            // pc stays on the halting instruction; resume skips past it.
            state  <= HALT;
            halted <= 1'b1;
          end else if (!stall) begin
`ifdef PC_ALIGN_CHECK_EN
            if (pc_new[1:0] != 2'b00) begin
              // Keep the last good pc for post-mortem debugging.
              state   <= FAULT;
              halted  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              pc         <= pc_new;
              cnt_branch <= sat_inc(cnt_branch, branched);
              cnt_jump   <= sat_inc(cnt_jump, is_jump);
            end
`else
            // The low bits are dropped, so a misaligned target still
            // lands on a word boundary.
            pc         <= pc_new & 32'hFFFF_FFFC;
            cnt_branch <= sat_inc(cnt_branch, branched);
            cnt_jump   <= sat_inc(cnt_jump, is_jump);
`endif
          end
        end
        HALT: begin
          if (resume) begin
            pc     <= pc_4;
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        FAULT: begin
          // Terminal state; only reset leaves it.
          state <= FAULT;
        end
        default: begin
          state  <= FAULT;
          halted <= 1'b1;
        end
      endcase
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  assign fault = fault_q;
`else
  // FAULT cannot be reached in this build, so fault is a constant.
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer, with RESET_PC = 32'h0000_3000 and
// CNT_W = 4 so that counter saturation is reached quickly. A behavioural
// model tracks the expected pc, the halted/faulted flags and the counters.
// Each step drives inputs, clocks once, advances the model and then compares
// every output against the model.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC  = 32'h0000_3000;
  localparam int          CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          stall;
  logic          halt;
  logic          resume;
  logic [31:0]   pc_new;
  logic          branched;
  logic          is_jump;
  logic [31:0]   pc;
  logic [31:0]   pc_4;
  logic          halted;
  logic          fault;
  logic [CW-1:0] cnt_cycle;
  logic [CW-1:0] cnt_branch;
  logic [CW-1:0] cnt_jump;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_faulted;
  int          m_cyc;
  int          m_br;
  int          m_jmp;

  pc_sequencer #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .halt(halt),
    .resume(resume), .pc_new(pc_new), .branched(branched),
    .is_jump(is_jump), .pc(pc), .pc_4(pc_4), .halted(halted),
    .fault(fault), .cnt_cycle(cnt_cycle), .cnt_branch(cnt_branch),
    .cnt_jump(cnt_jump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Advances the model by one clock edge, using the inputs currently driven.
  task automatic modelStep();
    if (!rst_n) begin
      m_pc = RST_PC; m_halted = 0; m_faulted = 0;
      m_cyc = 0; m_br = 0; m_jmp = 0;
    end else if (en) begin
      if (!m_halted) begin
        m_cyc = sat(m_cyc);
        if (halt) begin
          m_halted = 1;
        end else if (!stall) begin
`ifdef PC_ALIGN_CHECK_EN
          if (pc_new % 4 != 0) begin
            m_halted = 1; m_faulted = 1;
          end else begin
            m_pc = pc_new;
            if (branched) m_br = sat(m_br);
            if (is_jump) m_jmp = sat(m_jmp);
          end
`else
          m_pc = pc_new - (pc_new % 4);
          if (branched) m_br = sat(m_br);
          if (is_jump) m_jmp = sat(m_jmp);
`endif
        end
      end else if (!m_faulted && resume) begin
        m_pc = m_pc + 32'd4;
        m_halted = 0;
      end
    end
  endtask

  task automatic checkOne(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [31:0] exp_pc4;
    exp_pc4 = m_pc + 32'd4;
    checkOne("pc", pc, m_pc);
    checkOne("pc_4", pc_4, exp_pc4);
    checkOne("halted", {31'd0, halted}, {31'd0, m_halted});
    checkOne("fault", {31'd0, fault}, {31'd0, m_faulted});
    checkOne("cnt_cycle", {28'd0, cnt_cycle}, m_cyc);
    checkOne("cnt_branch", {28'd0, cnt_branch}, m_br);
    checkOne("cnt_jump", {28'd0, cnt_jump}, m_jmp);
  endtask

  // Drives one cycle of inputs, clocks the DUT, advances the model and
  // checks all outputs just after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic s,
                               input logic h, input logic rs,
                               input logic [31:0] pn, input logic b,
                               input logic j);
    rst_n = r; en = e; stall = s; halt = h; resume = rs;
    pc_new = pn; branched = b; is_jump = j;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  initial begin
    rst_n = 0; en = 0; stall = 0; halt = 0; resume = 0;
    pc_new = '0; branched = 0; is_jump = 0;
    m_pc = '0; m_halted = 0; m_faulted = 0; m_cyc = 0; m_br = 0; m_jmp = 0;
    #1;

    // Reset and sequential fetch from RESET_PC
    applyStimulus(0, 1, 0, 1, 1, 32'h1234_5678, 1, 1);
    checkOne("reset_pc", pc, 32'h0000_3000);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 0, 0, 0, m_pc + 32'd4, 0, 0);
    checkOne("seq_pc", pc, 32'h0000_300C);
    checkOne("seq_cycles", {28'd0, cnt_cycle}, 32'd3);

    // Taken branch, then jump
    applyStimulus(1, 1, 0, 0, 0, 32'h0000_0010, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 32'h0000_0040, 1, 0);
    checkOne("branch_pc", pc, 32'h0000_0040);
    applyStimulus(1, 1, 0, 0, 0, 32'h0000_0100, 0, 1);
    checkOne("jump_pc", pc, 32'h0000_0100);

    // Stall holds pc and the branch counter; en low freezes everything
    applyStimulus(1, 1, 1, 0, 0, 32'h0000_0800, 1, 0);
    applyStimulus(1, 1, 1, 0, 0, 32'h0000_0800, 1, 1);
    applyStimulus(1, 0, 0, 1, 0, 32'h0000_0900, 1, 1);
    applyStimulus(1, 0, 1, 0, 1, 32'h0000_0A00, 0, 1);

    // Halt at 0x20, hold, resume to 0x24
    applyStimulus(1, 1, 0, 0, 0, 32'h0000_0020, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 32'h0000_0500, 1, 1);
    checkOne("halt_pc", pc, 32'h0000_0020);
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 1, i[0], i[1], 0, 32'h0000_0600, 1, 1);
    applyStimulus(1, 0, 0, 0, 1, 32'h0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 32'h0000_0700, 1, 1);
    checkOne("resume_pc", pc, 32'h0000_0024);

    // halt+resume: halt wins in RUN, resume wins in HALT
    applyStimulus(1, 1, 0, 1, 1, 32'h0000_0800, 0, 0);
    applyStimulus(1, 1, 0, 1, 1, 32'h0000_0800, 0, 0);

    // Wrap of pc_4 at the top of the address space
    applyStimulus(1, 1, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
    checkOne("pc4_wrap", pc_4, 32'h0000_0000);

    // Branch and jump together; then 17 branches saturate cnt_branch
    applyStimulus(1, 1, 0, 0, 0, 32'h0000_0040, 1, 1);
    for (int i = 0; i < 17; i++)
      applyStimulus(1, 1, 0, 0, 0, m_pc + 32'd4, 1, 0);
    checkOne("branch_sat", {28'd0, cnt_branch}, 32'd15);

    // Reset while halted
    applyStimulus(1, 1, 0, 1, 0, 32'h0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0, 0);
    checkOne("reset_in_halt", {28'd0, cnt_branch}, 32'd0);

    // Misaligned target, then attempts to resume
    applyStimulus(1, 1, 0, 0, 0, 32'h0000_0042, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 0, 0, 1, 32'h0000_0100, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0, 0);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rnd_pc;
      rnd_pc = $urandom;
      if ($urandom_range(0, 3) != 0) rnd_pc[1:0] = 2'b00;
      applyStimulus(($urandom_range(0, 60) != 0),
                    ($urandom_range(0, 4) != 0),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 12) == 0),
                    ($urandom_range(0, 3) == 0),
                    rnd_pc,
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
